// File: rtl/sha_msg_streamer.sv
// ============================================================================
// Module  : sha_msg_streamer
// Brief   : Serializes a message descriptor and a 32-bit big-endian word
//           stream into the byte stream consumed by the SHA hash cores.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_msg_streamer #(
  parameter int LEN_W = 32,
  parameter int ID_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ID_W-1:0]  cmd_id,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             tvalid,
  input  logic             tready,
  output logic             tlast,
  output logic [ID_W-1:0]  tid,
  output logic [7:0]       tdata,
  output logic             busy,
  output logic             err_empty
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_id;
  logic [LEN_W-1:0] r_bytes_left;
  logic [LEN_W-1:0] r_words_left;
  logic [31:0]      r_hold;
  logic             r_hold_valid;
  logic [1:0]       r_idx;
  logic             r_first;

  logic [LEN_W:0]   w_len_p3;
  logic [LEN_W-1:0] w_words;
  logic             w_emit;
  logic             w_last_byte;
  logic             w_word_done;
  logic             w_load;

  // One extra bit keeps the rounding add from wrapping at the maximum length.
  assign w_len_p3    = {1'b0, cmd_len} + (LEN_W+1)'(3);
  assign w_words     = LEN_W'(w_len_p3 >> 2);

  assign w_emit      = (r_state == S_STREAM) && r_hold_valid;
  assign w_last_byte = (r_bytes_left == LEN_W'(1));
  assign w_word_done = w_emit && ((r_idx == 2'd3) || w_last_byte);

  assign cmd_ready   = (r_state == S_IDLE);
  // A new word may land in the same edge the holding register hands out its final byte.
  assign s_ready     = ((r_state == S_WAIT) || (r_state == S_STREAM)) &&
                       (r_words_left != '0) && (!r_hold_valid || w_word_done);
  assign w_load      = s_valid && s_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_id         <= '0;
      r_bytes_left <= '0;
      r_words_left <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_idx        <= 2'd0;
      r_first      <= 1'b0;
      tvalid       <= 1'b0;
      tlast        <= 1'b0;
      tid          <= '0;
      tdata        <= 8'd0;
      busy         <= 1'b0;
      err_empty    <= 1'b0;
    end else begin
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      tid       <= '0;
      err_empty <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              err_empty <= 1'b1;
            end else begin
              r_id         <= cmd_id;
              r_bytes_left <= cmd_len;
              r_words_left <= w_words;
              r_hold_valid <= 1'b0;
              r_first      <= 1'b1;
              busy         <= 1'b1;
              r_state      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (tready) r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_emit) begin
            tvalid       <= 1'b1;
            tdata        <= r_hold[31:24];
            tid          <= r_first ? r_id : '0;
            tlast        <= w_last_byte;
            r_first      <= 1'b0;
            r_hold       <= r_hold << 8;
            r_idx        <= r_idx + 2'd1;
            r_bytes_left <= r_bytes_left - LEN_W'(1);
            if (w_word_done) r_hold_valid <= 1'b0;
            if (w_last_byte) begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_load) begin
        r_hold       <= s_data;
        r_hold_valid <= 1'b1;
        r_idx        <= 2'd0;
        r_words_left <= r_words_left - LEN_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha_msg_streamer.sv
// ============================================================================
// Module  : tb_sha_msg_streamer
// Brief   : Directed table-driven bench for sha_msg_streamer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha_msg_streamer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_id = '0;
  logic [31:0] cmd_len = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic [31:0] tid;
  logic [7:0]  tdata;
  logic        busy;
  logic        err_empty;

  int n_pass  = 0;
  int n_total = 0;
  bit done    = 1'b0;
  bit abort   = 1'b0;

  sha_msg_streamer #(.LEN_W(32), .ID_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tvalid(tvalid), .tready(tready), .tlast(tlast), .tid(tid), .tdata(tdata),
    .busy(busy), .err_empty(err_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int len;
    int base;
    int stall;
    int gap;
    int abort_after;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_msg(input vec_t v);
    int nwords = (v.len + 3) / 4;
    logic [31:0] words[$];
    int nb = 0, nw = 0, t = 0, limit = 0;
    int data_err = 0, tid_err = 0, tlast_err = 0, busy_err = 0, stall_err = 0;
    int first_t = -1, last_t = -1;
    bit timed_out = 1'b0;
    bit aborted = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      logic [31:0] wd;
      for (int b = 0; b < 4; b++) wd[31-8*b -: 8] = 8'(v.base + 4*w + b);
      words.push_back(wd);
    end
    limit = v.len * 10 + v.stall + 100;
    done  = 1'b0;
    abort = 1'b0;
    fork
      begin : cmd_drv
        int tc;
        if (v.stall > 0) tready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_id = v.id; cmd_len = v.len;
        @(negedge clk);
        tc = 0;
        while (!cmd_ready && tc < 100) begin @(negedge clk); tc++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_len = '0;
        repeat (v.stall) @(posedge clk);
        #1 tready = 1'b1;
      end
      begin : feeder
        int w = 0;
        while (!done && !abort) begin
          @(posedge clk); #1;
          if (abort) break;
          if (w < nwords) begin
            if (v.gap > 0 && $urandom_range(99) < v.gap) s_valid = 1'b0;
            else begin s_valid = 1'b1; s_data = words[w]; end
          end else begin
            s_valid = 1'b1; s_data = 32'hDEADBEEF;
          end
          @(negedge clk);
          if (s_valid && s_ready) w++;
        end
        s_valid = 1'b0;
      end
      begin : monitor
        while (t < limit) begin
          @(negedge clk);
          t++;
          if (s_valid && s_ready) nw++;
          if (!tready && tvalid) stall_err++;
          if (tvalid) begin
            if (first_t < 0) first_t = t;
            last_t = t;
            if (tdata != 8'(v.base + nb)) data_err++;
            if (tid != ((nb == 0) ? 32'(v.id) : 32'd0)) tid_err++;
            if (tlast != (nb == v.len - 1)) tlast_err++;
            if (!tlast && (!busy || cmd_ready)) busy_err++;
            nb++;
            if (v.abort_after > 0 && nb == v.abort_after) begin
              #2 rstn = 1'b0;
              #1;
              check("rst_ctl_low", {tvalid, tlast, busy, err_empty, s_ready}, 0);
              check("rst_tid", tid, 0);
              check("rst_tdata", tdata, 0);
              check("rst_cmd_ready", cmd_ready, 1);
              abort   = 1'b1;
              aborted = 1'b1;
              @(posedge clk); #1 rstn = 1'b1;
              break;
            end
            if (tlast || nb >= v.len) break;
          end
        end
        if (t >= limit) timed_out = 1'b1;
        done = 1'b1;
      end
    join
    if (!aborted) begin
      @(negedge clk);
      check("timeout", timed_out, 0);
      check("byte_count", nb, v.len);
      check("data_err", data_err, 0);
      check("tid_err", tid_err, 0);
      check("tlast_err", tlast_err, 0);
      check("busy_err", busy_err, 0);
      check("words_taken", nw, nwords);
      check("stall_tvalid", stall_err, 0);
      if (v.gap == 0) check("bubbles", last_t - first_t + 1, v.len);
      check("post_idle", {busy, cmd_ready, tvalid, s_ready}, 4'b0100);
    end
  endtask

  initial begin
    //           id   len   base   stall gap abort
    vecs[0] = '{111,    5, 'h61,     0,  0,  0};
    vecs[1] = '{ 42,    4, 'h10,    20,  0,  0};
    vecs[2] = '{  5, 1000, 'h00,     0, 80,  0};
    vecs[3] = '{222,    3, 'h61,     0,  0,  0};
    vecs[4] = '{333,   64, 'h20,     0,  0,  0};
    vecs[5] = '{  9,    1, 'hA5,     3, 30,  0};
    vecs[6] = '{ 77,    7, 'hF0,     0,  0,  0};
    vecs[7] = '{ 55,   50, 'h30,     0,  0, 10};
    vecs[8] = '{ 56,   50, 'h40,     0,  0,  0};

    #12;
    check("reset_outputs", {tvalid, tlast, busy, err_empty, s_ready}, 0);
    check("reset_tid_tdata", {tid, tdata}, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 rstn = 1'b1;

    // Zero-length descriptor is dropped with a single-cycle error pulse.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_id = 7; cmd_len = 0;
    s_valid = 1'b1; s_data = 32'h01020304;
    @(negedge clk);
    check("empty_cmd_ready_pre", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("empty_err_pulse", err_empty, 1);
    check("empty_quiet", {tvalid, s_ready, busy}, 0);
    check("empty_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    check("empty_err_clear", err_empty, 0);
    check("empty_no_sready", s_ready, 0);
    s_valid = 1'b0;

    for (int i = 0; i < 9; i++) run_msg(vecs[i]);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
